calc_operand_sequencer: RTL and testbench

Front-end sequencer for the switch calculator. It collects operand A, operand B and the opcode from the input switches, one value per debounced "enter" button press. It then issues the triple to the calculator datapath over a valid/ready request and captures the returned result for display. It is the initiator side of the operand/result interface; the calculator core is the responder.

---
 rtl/calc_operand_sequencer.sv | 130 +++++++++++++
 tb/tb_calc_operand_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/calc_operand_sequencer.sv
// rtl/calc_operand_sequencer.sv - operand/opcode entry sequencer for the switch calculator
// Debounced enter button steps A -> B -> OP, then issues a valid/ready request and captures the result.
module calc_operand_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       op,
  output logic             req_valid,
  input  logic             req_ready,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [2:0]       phase
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_GET_A  = 3'b000,
    S_GET_B  = 3'b001,
    S_GET_OP = 3'b010,
    S_ISSUE  = 3'b011,
    S_WAIT   = 3'b100,
    S_SHOW   = 3'b101
  } state_t;

  state_t state, state_next;

  logic          sync1, btn_s;
  logic          deb, deb_q;
  logic [CW-1:0] cnt;
  logic          press;

  logic load_a, load_b, load_op, load_res, clr_res;

  // Counter only runs while the synchronised level disagrees with the debounced one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
      deb_q <= deb;
      if (btn_s == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= btn_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = deb & ~deb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_GET_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_GET_A:  if (press) state_next = S_GET_B;
      S_GET_B:  if (press) state_next = S_GET_OP;
      S_GET_OP: if (press) state_next = S_ISSUE;
      S_ISSUE:  if (req_ready) state_next = S_WAIT;
      S_WAIT:   if (rsp_valid) state_next = S_SHOW;
      S_SHOW:   if (press) state_next = S_GET_A;
      default:  state_next = S_GET_A;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_op   = 1'b0;
    load_res  = 1'b0;
    clr_res   = 1'b0;
    case (state)
      S_GET_A:  load_a    = press;
      S_GET_B:  load_b    = press;
      S_GET_OP: load_op   = press;
      S_ISSUE:  req_valid = 1'b1;
      S_WAIT:   load_res  = rsp_valid;
      S_SHOW:   clr_res   = press;
      default:  req_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a            <= '0;
      b            <= '0;
      op           <= 2'b00;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (load_a)  a  <= sw;
      if (load_b)  b  <= sw;
      if (load_op) op <= sw[1:0];
      if (load_res) begin
        result       <= rsp_data;
        result_valid <= 1'b1;
      end else if (clr_res) begin
        result_valid <= 1'b0;
      end
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// tb/tb_calc_operand_sequencer.sv - directed self-checking bench for calc_operand_sequencer
module tb_calc_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] a, b, result;
  logic [1:0] op;
  logic       req_valid, req_ready, rsp_valid, result_valid;
  logic [3:0] rsp_data;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;
  int rv_cycles = 0;

  calc_operand_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
    .a(a), .b(b), .op(op),
    .req_valid(req_valid), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .result(result), .result_valid(result_valid), .phase(phase)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (req_valid) rv_cycles++;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input logic [3:0] v);
    sw  = v;
    btn = 1'b1;
    repeat (8) tick();
    btn = 1'b0;
    repeat (8) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; sw = 4'h0; btn = 1'b0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 4'h0;

    // reset holds everything at zero despite button activity and ready
    for (int i = 0; i < 6; i++) begin
      btn = ~btn;
      repeat (2) tick();
    end
    btn = 1'b0;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_op", op, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_phase", phase, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_phase", phase, 0);

    // full transaction
    rv_cycles = 0;
    press_btn(4'd3);
    chk("full_phase_b", phase, 3'b001);
    press_btn(4'd5);
    chk("full_phase_op", phase, 3'b010);
    press_btn(4'd0);
    chk("full_phase_wait", phase, 3'b100);
    chk("full_a", a, 3);
    chk("full_b", b, 5);
    chk("full_op", op, 0);
    chk("full_req_cycles", rv_cycles, 1);
    rsp_data = 4'd8; rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("full_result", result, 8);
    chk("full_result_valid", result_valid, 1);
    chk("full_phase_show", phase, 3'b101);
    press_btn(4'd0);
    chk("show_clr_valid", result_valid, 0);
    chk("show_phase_a", phase, 0);
    chk("show_keep_result", result, 8);

    // short glitches never produce a press
    for (int i = 0; i < 10; i++) begin
      btn = 1'b1;
      repeat (3) tick();
      btn = 1'b0;
      repeat (6) tick();
    end
    chk("glitch_phase", phase, 0);

    // press timing: first sampled at edge N, acted on at edge N+6
    sw = 4'd7; btn = 1'b1;
    tick();
    repeat (5) tick();
    chk("deb_before_press", phase, 0);
    tick();
    chk("deb_at_press", phase, 3'b001);
    chk("deb_a", a, 7);
    repeat (4) tick();
    btn = 1'b0;
    repeat (10) tick();
    chk("deb_single_advance", phase, 3'b001);

    // backpressure
    do_reset();
    req_ready = 1'b0;
    press_btn(4'd9);
    press_btn(4'd2);
    press_btn(4'd1);
    chk("bp_phase_issue", phase, 3'b011);
    press_btn(4'hF);
    press_btn(4'hC);
    chk("bp_req_valid", req_valid, 1);
    chk("bp_a", a, 9);
    chk("bp_b", b, 2);
    chk("bp_op", op, 1);
    chk("bp_phase_hold", phase, 3'b011);
    req_ready = 1'b1;
    tick();
    chk("bp_phase_wait", phase, 3'b100);
    chk("bp_req_drop", req_valid, 0);

    // stray responses outside WAIT
    do_reset();
    req_ready = 1'b0;
    press_btn(4'd0);
    rsp_data = 4'hF; rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("stray_getb_result", result, 0);
    chk("stray_getb_valid", result_valid, 0);
    chk("stray_getb_phase", phase, 3'b001);
    press_btn(4'd0);
    press_btn(4'd0);
    chk("stray_issue_phase", phase, 3'b011);
    rsp_valid = 1'b1; req_ready = 1'b1;
    tick();
    rsp_valid = 1'b0; req_ready = 1'b0;
    chk("stray_accept_phase", phase, 3'b100);
    chk("stray_accept_result", result, 0);
    chk("stray_accept_valid", result_valid, 0);
    rsp_data = 4'h1; rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("stray_wait_result", result, 1);
    chk("stray_wait_valid", result_valid, 1);

    // asynchronous reset in the middle of a request
    do_reset();
    req_ready = 1'b0;
    press_btn(4'd3);
    press_btn(4'd5);
    press_btn(4'd2);
    chk("mid_issue", req_valid, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_req_valid", req_valid, 0);
    chk("mid_a", a, 0);
    chk("mid_b", b, 0);
    chk("mid_op", op, 0);
    chk("mid_phase", phase, 0);
    tick();
    rst_n = 1'b1;
    req_ready = 1'b1;
    tick();
    press_btn(4'd6);
    chk("mid_restart_phase", phase, 3'b001);
    chk("mid_restart_a", a, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
